// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, init FSM states and default mode word.
// Reused by the init, auto-refresh, write and read blocks.
package sdram_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PRE,
        ST_TRP,
        ST_AR,
        ST_TRFC,
        ST_MRS,
        ST_TMRD,
        ST_DONE
    } init_state_t;

    // CAS latency 3, sequential burst, full page
    localparam int unsigned MODE_REG_DEFAULT = 32'h0000_0037;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_param_if.sv
// Command/address bus between the init sequencer (master) and the SDRAM arbiter (slave).
interface sdram_init_param_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned BA_W   = 2
) ();

    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_bank_addr;
    logic [ADDR_W-1:0] init_addr;
    logic              init_end;
    logic              reinit_req;

    modport master (
        output init_cmd,
        output init_bank_addr,
        output init_addr,
        output init_end,
        input  reinit_req
    );

    modport slave (
        input  init_cmd,
        input  init_bank_addr,
        input  init_addr,
        input  init_end,
        output reinit_req
    );

endinterface

// File: rtl/sdram_timer.sv
// Loadable down-counter: a load strobe presets the count, which then decrements to zero and holds.
module sdram_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sdram_init_param.sv
// Parametrised SDRAM power-up initialisation sequencer:
// power-up wait, PRECHARGE ALL, AR_NUM x AUTO REFRESH, LOAD MODE REGISTER, then init_end.
module sdram_init_param import sdram_pkg::*; #(
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter int unsigned T_POWER_US   = 200,
    parameter int unsigned T_RP_CYC     = 2,
    parameter int unsigned T_RFC_CYC    = 7,
    parameter int unsigned T_MRD_CYC    = 3,
    parameter int unsigned AR_NUM       = 8,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned BA_W         = 2,
    parameter int unsigned MODE_REG     = MODE_REG_DEFAULT
) (
    input logic                clk,
    input logic                rst_n,
    sdram_init_param_if.master bus
);

    localparam int unsigned POWER_CYC = CLK_FREQ_MHZ * T_POWER_US;
    localparam int unsigned CNT_MAX   = max4(POWER_CYC, T_RP_CYC, T_RFC_CYC, T_MRD_CYC);
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned AR_W      = $clog2(AR_NUM + 1);

    // The timer is loaded with (phase length - 1) on the edge that issues the command
    localparam logic [CNT_W-1:0] LD_POWER = CNT_W'(POWER_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_CYC - 1);
    localparam logic [AR_W-1:0]  AR_LAST  = AR_W'(AR_NUM);
    localparam logic [ADDR_W-1:0] MODE_WORD = ADDR_W'(MODE_REG);

    if (T_RP_CYC < 1 || T_RFC_CYC < 1 || T_MRD_CYC < 1 || AR_NUM < 1 ||
        ADDR_W < 11 || POWER_CYC < 1) begin : g_param_check
        $error("sdram_init_param: illegal timing, refresh count or address width parameter");
    end

    init_state_t       state;
    init_state_t       next_state;
    logic              wait_armed;
    logic              reinit_pend;
    logic [AR_W-1:0]   ar_cnt;

    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_done;

    logic [3:0]        cmd_d;
    logic [BA_W-1:0]   ba_d;
    logic [ADDR_W-1:0] addr_d;
    logic              end_d;

    logic [3:0]        cmd_q;
    logic [BA_W-1:0]   ba_q;
    logic [ADDR_W-1:0] addr_q;
    logic              end_q;

    sdram_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // reinit_pend only captures a request on an edge where the FSM was already in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            wait_armed  <= 1'b0;
            reinit_pend <= 1'b0;
            ar_cnt      <= '0;
        end else begin
            state       <= next_state;
            wait_armed  <= 1'b1;
            reinit_pend <= (state == ST_DONE) && bus.reinit_req;
            if (next_state == ST_PRE) begin
                ar_cnt <= '0;
            end else if (next_state == ST_AR) begin
                ar_cnt <= ar_cnt + AR_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_WAIT:         if (wait_armed && timer_done) next_state = ST_PRE;
            ST_PRE, ST_TRP:  next_state = timer_done ? ST_AR : ST_TRP;
            ST_AR, ST_TRFC: begin
                if (!timer_done)           next_state = ST_TRFC;
                else if (ar_cnt == AR_LAST) next_state = ST_MRS;
                else                       next_state = ST_AR;
            end
            ST_MRS, ST_TMRD: next_state = timer_done ? ST_DONE : ST_TMRD;
            ST_DONE:         if (reinit_pend) next_state = ST_PRE;
            default:         next_state = ST_WAIT;
        endcase
    end

    // Outputs and timer reloads are decoded from the state being entered, so they land with it
    always_comb begin
        cmd_d      = CMD_NOP;
        ba_d       = '1;
        addr_d     = '1;
        end_d      = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        if (state == ST_WAIT && !wait_armed) begin
            timer_load = 1'b1;
            timer_val  = LD_POWER;
        end
        case (next_state)
            ST_PRE: begin
                cmd_d      = CMD_PRECHARGE;
                timer_load = 1'b1;
                timer_val  = LD_RP;
            end
            ST_AR: begin
                cmd_d      = CMD_AUTO_REFRESH;
                timer_load = 1'b1;
                timer_val  = LD_RFC;
            end
            ST_MRS: begin
                cmd_d      = CMD_LOAD_MODE;
                ba_d       = '0;
                addr_d     = MODE_WORD;
                timer_load = 1'b1;
                timer_val  = LD_MRD;
            end
            ST_DONE: end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CMD_NOP;
            ba_q   <= '1;
            addr_q <= '1;
            end_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            ba_q   <= ba_d;
            addr_q <= addr_d;
            end_q  <= end_d;
        end
    end

    assign bus.init_cmd       = cmd_q;
    assign bus.init_bank_addr = ba_q;
    assign bus.init_addr      = addr_q;
    assign bus.init_end       = end_q;

endmodule

// File: tb/tb_sdram_init_param.sv
// Directed bench for sdram_init_param: default build plus a short-timing build with
// reinit requests and an asynchronous mid-sequence reset.
module tb_sdram_init_param;
    import sdram_pkg::*;

    localparam logic [19:0] RST_VEC = {4'b0111, 2'b11, 13'h1FFF, 1'b0};

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sdram_init_param_if #(.ADDR_W(13), .BA_W(2)) if_a ();
    sdram_init_param_if #(.ADDR_W(13), .BA_W(2)) if_b ();

    sdram_init_param dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (if_a.master)
    );

    sdram_init_param #(
        .CLK_FREQ_MHZ (10),
        .T_POWER_US   (1),
        .AR_NUM       (2),
        .T_RFC_CYC    (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (if_b.master)
    );

    logic [19:0] vec_a;
    logic [19:0] vec_b;
    assign vec_a = {if_a.init_cmd, if_a.init_bank_addr, if_a.init_addr, if_a.init_end};
    assign vec_b = {if_b.init_cmd, if_b.init_bank_addr, if_b.init_addr, if_b.init_end};

    // Expected bus in cycle c for a run whose PRECHARGE lands in cycle base
    function automatic logic [19:0] exp_vec(input int c, input int base, input int t_rp,
                                            input int t_rfc, input int ar_num, input int t_mrd);
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        fin;
        int          m;
        m    = base + t_rp + ar_num * t_rfc;
        cmd  = 4'b0111;
        ba   = 2'b11;
        addr = 13'h1FFF;
        fin  = (c >= m + t_mrd);
        if (c == base) cmd = 4'b0010;
        for (int k = 0; k < ar_num; k++) begin
            if (c == base + t_rp + k * t_rfc) cmd = 4'b0001;
        end
        if (c == m) begin
            cmd  = 4'b0000;
            ba   = 2'b00;
            addr = 13'h0037;
        end
        return {cmd, ba, addr, fin};
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic req_v);
        rst_n_b        = rst_v;
        if_b.reinit_req = req_v;
    endtask

    task automatic checkOutput(input string tag, input int cyc,
                               input logic [19:0] got, input logic [19:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        rst_n_a         = 1'b0;
        if_a.reinit_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_a", -1, vec_a, RST_VEC);
        checkOutput("reset_b", -1, vec_b, RST_VEC);

        // Short build: level request during WAIT/sequence is ignored, pulse in DONE reruns
        $display("[TB] short-timing run with held and pulsed reinit_req");
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (c < 31) checkOutput("short_seq", c, vec_b, exp_vec(c, 10, 2, 4, 2, 3));
            else        checkOutput("reinit_seq", c, vec_b, exp_vec(c, 31, 2, 4, 2, 3));
            if (c == 4)  applyStimulus(1'b1, 1'b1);
            if (c == 15) applyStimulus(1'b1, 1'b0);
            if (c == 29) applyStimulus(1'b1, 1'b1);
            if (c == 30) applyStimulus(1'b1, 1'b0);
        end

        // Asynchronous reset pulse while AUTO REFRESH #1 is on the bus
        $display("[TB] asynchronous reset during refresh phase");
        applyStimulus(1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            @(posedge clk);
            #1;
            checkOutput("pre_async", c, vec_b, exp_vec(c, 10, 2, 4, 2, 3));
        end
        #2;
        rst_n_b = 1'b0;
        #1;
        checkOutput("async_rst", 16, vec_b, RST_VEC);
        #2;
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk);
            #1;
            checkOutput("restart_seq", c, vec_b, exp_vec(c, 10, 2, 4, 2, 3));
        end

        // Default build: PRE @20000, AR @20002+7k, LOAD_MODE @20058, init_end @20061
        $display("[TB] default-parameter run");
        rst_n_a = 1'b1;
        for (int c = 0; c <= 20070; c++) begin
            @(posedge clk);
            #1;
            checkOutput("default_seq", c, vec_a, exp_vec(c, 20000, 2, 7, 8, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
